muldiv: RTL and testbench
=========================

Name: muldiv

Overview:
- Iterative multiply/divide unit that sits beside the combinational ALU in the RISC5 execute stage.
- Handles the MUL and DIV function codes that the ALU returns as zero.
- The execute-stage result mux takes res_lo into the destination register and res_hi into the H register.
- Radix-2 shift-add/subtract datapath: one iteration per clock, start/busy/done handshake used by the pipeline stall logic.

Parameters:
- WIDTH, 32, operand width in bits. Result halves are WIDTH each. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  system reset; asynchronous, active-low
- start  input  1  launch an operation; sampled only when busy=0
- op  input  1  0 = multiply, 1 = divide
- u  input  1  0 = signed mode, 1 = unsigned mode
- op1  input  WIDTH  multiplicand / dividend
- op2  input  WIDTH  multiplier / divisor
- busy  output  1  operation in progress; execute stage stalls
- done  output  1  one-cycle pulse; results valid
- res_lo  output  WIDTH  product bits [WIDTH-1:0] / quotient
- res_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH] / remainder

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, res_lo=0, res_hi=0; iteration counter=0.
- Reset asserted mid-operation aborts the operation immediately. Nothing resumes after release.
- States and transitions:
  - IDLE -> RUN when start=1 at a clock edge. op, u, op1 and op2 are latched at that edge.
  - RUN: busy=1 for exactly WIDTH cycles, counter counts 0..WIDTH-1.
  - RUN -> FIN after the last iteration.
  - FIN: busy=1, done=1 for one cycle. res_lo and res_hi are updated at entry to FIN.
  - FIN -> IDLE unconditionally.
- Latency: done is high in the (WIDTH+1)th cycle after the start edge, i.e. 33 cycles for WIDTH=32. The next start is accepted in the cycle after done.
- start while busy=1 (RUN or FIN): ignored. Inputs are not resampled.
- res_lo and res_hi hold their values from FIN until the next FIN or reset.
- Operand changes after the start edge have no effect.
- Multiply:
  - Full 2*WIDTH-bit product.
  - u=0: op1 and op2 are two's-complement signed.
  - u=1: both unsigned.
  - No overflow indication.
- Divide:
  - The divisor is always interpreted unsigned.
  - u=1: dividend unsigned; quotient = op1 / op2, remainder = op1 mod op2.
  - u=0, op1 >= 0: same as the unsigned case.
  - u=0, op1 < 0: floored division (Oberon DIV/MOD).
    - Compute q', r' = unsigned divide of (-op1-1) by op2.
    - Quotient = ~q'. Remainder = op2-1-r'.
    - Remainder is always in [0, op2-1].
  - Divide by zero (op2=0, any u): quotient = all ones, remainder = op1 (as latched). Latency is unchanged.
- Edge inputs:
  - Most negative dividend (0x80000000) in signed mode must produce the correct floored result.
  - Dividend 0 gives quotient 0, remainder 0.

Decomposition:
- Shared CPU package holds:
  - op encodings MD_MUL=1'b0, MD_DIV=1'b1
  - state encoding IDLE/RUN/FIN
  - DIV0_QUOT constant (all ones)
- No sub-module: counter, FSM and the shared shift register fit one module of roughly 150-250 lines.

Test Plan:
- Signed mul: op=0, u=0, op1=7, op2=0xFFFFFFFD, start for 1 cycle -> busy=1 next cycle; done pulse 33 cycles after start; res_hi=0xFFFFFFFF, res_lo=0xFFFFFFEB.
- Unsigned mul: op1=op2=0xFFFFFFFF, u=1 -> res_hi=0xFFFFFFFE, res_lo=0x00000001. With u=0 -> res_hi=0, res_lo=1.
- Divide:
  - u=1, 100/7 -> res_lo=14, res_hi=2.
  - u=0, op1=0xFFFFFFF9 (-7), op2=2 -> res_lo=0xFFFFFFFC, res_hi=1.
  - u=0, op1=0x80000000, op2=3 -> res_lo=0xD5555555, res_hi=1.
- Divide by zero: op1=5, op2=0 -> res_lo=0xFFFFFFFF, res_hi=5, done at cycle 33.
- Handshake and reset:
  - Second start at cycle 10 with different operands -> ignored; first result unchanged.
  - Results hold after done; back-to-back start in the cycle after done is accepted.
  - rst=0 at cycle 12 of an operation -> busy, done and results go to 0 without a clock edge; no done pulse after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// operation encodings, FSM state type and the divide-by-zero quotient.
package muldiv_pkg;

  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } md_state_e;

  localparam int                  MD_MAX_W  = 64;
  localparam logic [MD_MAX_W-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/muldiv.sv
// Radix-2 iterative multiply/divide unit beside the ALU: one shift-add or
// shift-subtract step per clock, start/busy/done handshake for pipeline stalls.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             u,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;

  logic [WIDTH:0]     add_v;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  // Signed multiply runs on magnitudes and negates the product at the end.
  // Negative signed dividends are divided as ~op1 (= -op1-1) so the floored
  // quotient/remainder fall out as ~q' and op2-1-r' without a correction step.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    b_d       = b_q;
    op_d      = op_q;
    neg_d     = neg_q;
    res_lo_d  = res_lo_q;
    res_hi_d  = res_hi_q;
    add_v     = sh_q[0] ? ({1'b0, acc_q} + {1'b0, b_q}) : {1'b0, acc_q};
    div_trial = {1'b0, acc_q, sh_q[WIDTH-1]} - {2'b00, b_q};
    prod      = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_d   = '0;
          op_d    = op;
          if (op == MD_MUL) begin
            neg_d = ~u & (op1[WIDTH-1] ^ op2[WIDTH-1]);
            sh_d  = u ? op1 : abs_val(op1);
            b_d   = u ? op2 : abs_val(op2);
          end else begin
            neg_d = ~u & op1[WIDTH-1];
            sh_d  = neg_d ? ~op1 : op1;
            b_d   = op2;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q == MD_MUL) begin
          acc_d = add_v[WIDTH:1];
          sh_d  = {add_v[0], sh_q[WIDTH-1:1]};
        end else if (!div_trial[WIDTH+1]) begin
          acc_d = div_trial[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == LAST) begin
          state_d = FIN;
          cnt_d   = '0;
          if (op_q == MD_MUL) begin
            prod     = neg_q ? -{acc_d, sh_d} : {acc_d, sh_d};
            res_lo_d = prod[WIDTH-1:0];
            res_hi_d = prod[2*WIDTH-1:WIDTH];
          end else begin
            res_lo_d = (b_q == '0) ? DIV0_QUOT[WIDTH-1:0] : (neg_q ? ~sh_d : sh_d);
            res_hi_d = neg_q ? (b_q + ~acc_d) : acc_d;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      b_q      <= '0;
      op_q     <= MD_MUL;
      neg_q    <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      b_q      <= b_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FIN);
  assign res_lo = res_lo_q;
  assign res_hi = res_hi_q;

endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: expected results come from an arithmetic
// reference model and are popped when each done pulse arrives.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_s = 1'b0;
  logic        op_s = 1'b0;
  logic        u_s = 1'b0;
  logic [31:0] op1_s = '0;
  logic [31:0] op2_s = '0;
  logic        busy, done;
  logic [31:0] res_lo, res_hi;

  muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start_s), .op(op_s), .u(u_s),
    .op1(op1_s), .op2(op2_s), .busy(busy), .done(done),
    .res_lo(res_lo), .res_hi(res_hi)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] obs_lo, obs_hi;
  int          obs_lat;
  logic        obs_busy1;
  bit          timed_out;

  function automatic exp_t model(bit opv, bit uv, logic [31:0] a, logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sd, q, r;
    int          ai;
    if (!opv) begin
      if (uv) p = {32'b0, a} * {32'b0, b};
      else    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      e.lo = p[31:0];
      e.hi = p[63:32];
    end else if (b == 32'd0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = a;
    end else begin
      ai = a;
      sa = uv ? longint'({32'b0, a}) : longint'(ai);
      sd = longint'({32'b0, b});
      if (sa >= 0) q = sa / sd;
      else         q = -((-sa + sd - 1) / sd);
      r = sa - q * sd;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end
    return e;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that raised done.
  task automatic run_op(input bit opv, input bit uv, input logic [31:0] a, input logic [31:0] b);
    op_s = opv; u_s = uv; op1_s = a; op2_s = b; start_s = 1'b1;
    sb.push_back(model(opv, uv, a, b));
    @(posedge clk); #1;
    start_s = 1'b0; op_s = ~opv; u_s = ~uv; op1_s = ~a; op2_s = b ^ 32'h5A5A_5A5A;
    obs_busy1 = busy;
    obs_lat   = 0;
    timed_out = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin
        obs_lat   = c;
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    obs_lo = res_lo;
    obs_hi = res_hi;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00 || res_lo !== 32'd0 || res_hi !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b lo=%h hi=%h want 0 0 0 0", busy, done, res_lo, res_hi);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_mul();
    exp_t e;
    logic [31:0] a, b;
    run_op(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD);
    e = sb.pop_front();
    checks++;
    if (obs_busy1 !== 1'b1) begin
      errors++; $display("FAIL mul_busy_after_start got %b want 1", obs_busy1);
    end
    checks++;
    if (timed_out || obs_lat != 33) begin
      errors++; $display("FAIL mul_latency got %0d want 33", obs_lat);
    end
    checks++;
    if (obs_lo !== e.lo || obs_hi !== e.hi || e.hi !== 32'hFFFF_FFFF || e.lo !== 32'hFFFF_FFEB) begin
      errors++; $display("FAIL mul_signed got %h_%h want ffffffff_ffffffeb", obs_hi, obs_lo);
    end
    @(posedge clk); #1;
    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    e = sb.pop_front();
    checks++;
    if (timed_out || obs_lo !== e.lo || obs_hi !== e.hi) begin
      errors++; $display("FAIL mul_unsigned_max got %h_%h want %h_%h", obs_hi, obs_lo, e.hi, e.lo);
    end
    @(posedge clk); #1;
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    e = sb.pop_front();
    checks++;
    if (timed_out || obs_lo !== e.lo || obs_hi !== e.hi) begin
      errors++; $display("FAIL mul_signed_m1 got %h_%h want %h_%h", obs_hi, obs_lo, e.hi, e.lo);
    end
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      run_op(1'b0, i[0], a, b);
      e = sb.pop_front();
      checks++;
      if (timed_out || obs_lo !== e.lo || obs_hi !== e.hi) begin
        errors++; $display("FAIL mul_rand u=%0d a=%h b=%h got %h_%h want %h_%h", i[0], a, b, obs_hi, obs_lo, e.hi, e.lo);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    exp_t e;
    logic [31:0] a, b;
    logic [31:0] va [5] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] vb [5] = '{32'd7, 32'd2, 32'd3, 32'd9, 32'd1};
    bit          vu [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run_op(1'b1, vu[i], va[i], vb[i]);
      e = sb.pop_front();
      checks++;
      if (timed_out || obs_lo !== e.lo || obs_hi !== e.hi) begin
        errors++; $display("FAIL div_vec%0d got q=%h r=%h want q=%h r=%h", i, obs_lo, obs_hi, e.lo, e.hi);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom_range(1, 5000);
      if (i >= 3) b = $urandom | 32'h1;
      run_op(1'b1, i[0], a, b);
      e = sb.pop_front();
      checks++;
      if (timed_out || obs_lo !== e.lo || obs_hi !== e.hi) begin
        errors++; $display("FAIL div_rand u=%0d a=%h b=%h got q=%h r=%h want q=%h r=%h", i[0], a, b, obs_lo, obs_hi, e.lo, e.hi);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div0();
    exp_t e;
    run_op(1'b1, 1'b1, 32'd5, 32'd0);
    e = sb.pop_front();
    checks++;
    if (timed_out || obs_lat != 33 || obs_lo !== e.lo || obs_hi !== e.hi) begin
      errors++; $display("FAIL div0_unsigned got q=%h r=%h lat=%0d want q=%h r=%h lat=33", obs_lo, obs_hi, obs_lat, e.lo, e.hi);
    end
    @(posedge clk); #1;
    run_op(1'b1, 1'b0, 32'hFFFF_FF00, 32'd0);
    e = sb.pop_front();
    checks++;
    if (timed_out || obs_lo !== e.lo || obs_hi !== e.hi) begin
      errors++; $display("FAIL div0_signed_neg got q=%h r=%h want q=%h r=%h", obs_lo, obs_hi, e.lo, e.hi);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   cur;
    bit   extra;
    op_s = 1'b0; u_s = 1'b1; op1_s = 32'd1234; op2_s = 32'd5678; start_s = 1'b1;
    sb.push_back(model(1'b0, 1'b1, 32'd1234, 32'd5678));
    @(posedge clk); #1;
    start_s = 1'b0;
    cur = 1;
    repeat (9) begin @(posedge clk); #1; cur++; end
    op_s = 1'b1; u_s = 1'b0; op1_s = 32'd99; op2_s = 32'd4; start_s = 1'b1;
    @(posedge clk); #1; cur++;
    start_s = 1'b0;
    while (!done && cur < 100) begin @(posedge clk); #1; cur++; end
    e = sb.pop_front();
    checks++;
    if (cur != 33 || res_lo !== e.lo || res_hi !== e.hi) begin
      errors++; $display("FAIL ignore_start got lo=%h hi=%h cyc=%0d want lo=%h hi=%h cyc=33", res_lo, res_hi, cur, e.lo, e.hi);
    end
    extra = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (busy || done) extra = 1'b1; end
    checks++;
    if (extra || res_lo !== e.lo || res_hi !== e.hi) begin
      errors++; $display("FAIL ignore_no_rerun got extra=%b lo=%h hi=%h want 0 %h %h", extra, res_lo, res_hi, e.lo, e.hi);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    run_op(1'b0, 1'b0, 32'hFFFF_FFF0, 32'd3);
    e = sb.pop_front();
    checks++;
    if (timed_out || obs_lo !== e.lo || obs_hi !== e.hi) begin
      errors++; $display("FAIL b2b_first got %h_%h want %h_%h", obs_hi, obs_lo, e.hi, e.lo);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || res_lo !== e.lo || res_hi !== e.hi) begin
      errors++; $display("FAIL b2b_hold got busy=%b done=%b %h_%h want 0 0 %h_%h", busy, done, res_hi, res_lo, e.hi, e.lo);
    end
    run_op(1'b1, 1'b0, 32'hFFFF_FFF0, 32'd3);
    e = sb.pop_front();
    checks++;
    if (timed_out || obs_lat != 33 || obs_lo !== e.lo || obs_hi !== e.hi) begin
      errors++; $display("FAIL b2b_second got q=%h r=%h lat=%0d want q=%h r=%h lat=33", obs_lo, obs_hi, obs_lat, e.lo, e.hi);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    bit extra;
    op_s = 1'b0; u_s = 1'b1; op1_s = 32'd300; op2_s = 32'd400; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00 || res_lo !== 32'd0 || res_hi !== 32'd0) begin
      errors++; $display("FAIL reset_midop got busy=%b done=%b lo=%h hi=%h want 0 0 0 0", busy, done, res_lo, res_hi);
    end
    @(negedge clk); rst = 1'b1;
    extra = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (busy || done) extra = 1'b1; end
    checks++;
    if (extra) begin
      errors++; $display("FAIL reset_no_resume got busy/done activity=%b want 0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div0();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
